// File: rtl/bcd_seq_converter_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_seq_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADJ   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [3:0] digit_t;

  localparam digit_t ADD3_THRESH   = 4'd5;
  localparam digit_t BCD_MAX_DIGIT = 4'd9;
  localparam digit_t BCD_ILLEGAL   = 4'hF;

  // Number of decimal digits needed to hold 2^width-1.
  function automatic int min_bcd_digits(input int width);
    longint unsigned max_v;
    int n;
    max_v = (64'd1 << width) - 64'd1;
    n = 1;
    while (max_v >= 64'd10) begin
      max_v = max_v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_dd_add3_cell.sv
// Combinational add-3 correction for one BCD digit; values above 9 saturate
// to BCD_ILLEGAL and raise illegal.
module dd_add3_cell
  import bcd_seq_converter_pkg::*;
(
  input  digit_t digit_in,
  output digit_t digit_out,
  output logic   illegal
);

  always_comb begin
    digit_out = digit_in;
    illegal   = 1'b0;
    if (digit_in > BCD_MAX_DIGIT) begin
      digit_out = BCD_ILLEGAL;
      illegal   = 1'b1;
    end else if (digit_in >= ADD3_THRESH) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one shared add-3 cell visits each digit
// in turn (ADJ), then the scratch register shifts left once (SHIFT).
//
//   state | meaning
//   IDLE  | waiting for start; captures bin_in on acceptance
//   ADJ   | correct BCD digit dig_q through the shared cell
//   SHIFT | shift {bcd,bin} left by one; after WIDTH shifts publish result
//   DONE  | result and err presented with a one-cycle done pulse
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                err
);

  localparam int BW = 4 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam int MIN_DIGITS = min_bcd_digits(WIDTH);

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $fatal(1, "bcd_seq_converter: DIGITS too small for WIDTH");
  end

  state_e          state_q, state_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             err_acc_q, err_acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    bcd_out_q, bcd_out_d;
  logic             err_q, err_d;

  digit_t           cell_in, cell_out;
  logic             cell_err;
  logic [BW-1:0]    bcd_shl;

  assign cell_in = bcd_q[dig_q*4 +: 4];

  dd_add3_cell u_cell (
    .digit_in  (cell_in),
    .digit_out (cell_out),
    .illegal   (cell_err)
  );

  // The BCD MSB falls off here; the elaboration check keeps it always zero.
  assign bcd_shl = {bcd_q[BW-2:0], bin_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    dig_d     = dig_q;
    bitcnt_d  = bitcnt_q;
    err_acc_d = err_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_out_d = bcd_out_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d     = '0;
          bin_d     = bin_in;
          dig_d     = '0;
          bitcnt_d  = '0;
          err_acc_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ADJ;
        end
      end
      ADJ: begin
        bcd_d[dig_q*4 +: 4] = cell_out;
        err_acc_d = err_acc_q | cell_err;
        if (dig_q == LAST_DIG) begin
          state_d = SHIFT;
        end else begin
          dig_d = dig_q + DW'(1);
        end
      end
      SHIFT: begin
        bcd_d = bcd_shl;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        dig_d = '0;
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_d  = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          bcd_out_d = bcd_shl;
          err_d     = err_acc_q;
          state_d   = DONE;
        end else begin
          bitcnt_d = bitcnt_q + CW'(1);
          state_d  = ADJ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      dig_q     <= '0;
      bitcnt_q  <= '0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      dig_q     <= dig_d;
      bitcnt_q  <= bitcnt_d;
      err_acc_q <= err_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_out_q <= bcd_out_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: an acceptance model pushes expected
// results, a separate monitor pops them when done pulses.
module tb_bcd_seq_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;
  // Cycles from the accepting edge to the DONE cycle.
  localparam int LAT    = WIDTH * (DIGITS + 1) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] bin_in = '0;
  logic             busy;
  logic             done;
  logic [BW-1:0]    bcd_out;
  logic             err;

  bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] bcd;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            model_cnt = 0;
  logic          hand_valid = 1'b0;
  logic [BW-1:0] hand_exp = '0;
  logic [BW-1:0] hold_exp = '0;
  logic          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Acceptance model: a request is taken only when the converter is idle.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      model_cnt = 0;
      q.delete();
    end else if (model_cnt == 0 && start) begin
      e.bcd = hand_valid ? hand_exp : to_bcd(int'(bin_in));
      e.acc = cyc;
      q.push_back(e);
      model_cnt = LAT;
    end else if (model_cnt > 0) begin
      model_cnt--;
    end
    cyc++;
  end

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      hold_exp = '0;
    end else if (mon_en) begin
      chk("busy", 32'(busy), 32'(model_cnt >= 2));
      if (q.size() > 0 && (cyc - q[0].acc) > LAT) begin
        e = q.pop_front();
        chk("done_missing", 32'(cyc - e.acc), 32'(LAT));
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.acc), 32'(LAT));
          chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
          chk("err", 32'(err), 32'(0));
          hold_exp = e.bcd;
        end
      end else begin
        chk("bcd_hold", 32'(bcd_out), 32'(hold_exp));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((model_cnt != 0 || q.size() != 0) && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (model_cnt != 0 || q.size() != 0)
      chk("idle_timeout", 32'(q.size()), 32'(0));
    @(negedge clk);
  endtask

  task automatic issue(input int v, input logic use_hand, input logic [BW-1:0] hexp);
    @(negedge clk);
    start      = 1'b1;
    bin_in     = WIDTH'(v);
    hand_valid = use_hand;
    hand_exp   = hexp;
    @(negedge clk);
    start      = 1'b0;
    hand_valid = 1'b0;
    bin_in     = ~bin_in;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_bcd", 32'(bcd_out), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    mon_en = 1'b1;

    issue(255, 1'b1, 12'h255); wait_idle();
    issue(0,   1'b1, 12'h000); wait_idle();
    issue(99,  1'b1, 12'h099); wait_idle();
    issue(100, 1'b1, 12'h100); wait_idle();

    // Start held high with bin_in changing every cycle.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3 * (LAT + 1) + 1; i++) begin
      bin_in = WIDTH'(i * 37 + 11);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Extra start pulses at cycle 5 and in the DONE cycle are ignored.
    issue(77, 1'b1, 12'h077);
    repeat (4) @(negedge clk);
    start = 1'b1; bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 6) @(negedge clk);
    start = 1'b1; bin_in = 8'd201;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (LAT + 2) @(negedge clk);
    chk("ignored_hold", 32'(bcd_out), 32'h077);

    // Reset in the middle of a conversion.
    issue(123, 1'b1, 12'h123);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_bcd", 32'(bcd_out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    issue(42, 1'b1, 12'h042); wait_idle();

    for (int v = 0; v < (1 << WIDTH); v++) begin
      issue(v, 1'b0, '0);
      wait_idle();
    end

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
